pipelined_seg_adder: RTL
========================

# pipelined_seg_adder

Parametrised, pipelined successor to the single-stage 16-bit full-adder datapath. It takes two WIDTH-bit operands packed in one input word, with a carry-in and a 2-bit op mode, and resolves the carry chain SEG bits per pipeline stage. A valid/ready handshake with full back-pressure lets it sit between the data-generator and checker stages of the random-design fabric. It adds subtraction, signed overflow, bitwise XOR3/majority modes and stall support, which the single-stage adder does not have.

## Interface
- WIDTH, 16: operand width; must be a multiple of SEG, ≥ SEG.
- SEG, 4: carry-chain segment width per pipeline stage; NSEG = WIDTH/SEG.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- data_in  input  2*WIDTH  a = data_in[WIDTH-1:0], b = data_in[2*WIDTH-1:WIDTH].
- cin  input  1  carry/borrow-in, sampled with data_in.
- mode  input  2  00 ADD, 01 SUB, 10 XOR3, 11 MAJ; sampled with data_in.
- in_valid  input  1  operand word present.
- in_ready  output  1  block accepts this cycle; combinational = !(out_valid && !out_ready).
- data_out  output  WIDTH  result.
- cout  output  1  carry-out (ADD/SUB), 0 otherwise.
- ovf  output  1  signed overflow (ADD/SUB), 0 otherwise.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- ADD: {cout, data_out} = a + b + cin.
- SUB: data_out = a + ~b + !cin (a − b − cin mod 2^WIDTH); cout = carry out of that sum (1 = no borrow).
- XOR3: data_out = a ^ b ^ {WIDTH{cin}}; cout = 0, ovf = 0.
- MAJ: data_out = (a&b)|(a&C)|(b&C), C = {WIDTH{cin}}; cout = 0, ovf = 0.
- ovf (ADD): a[MSB]==b[MSB] && data_out[MSB]!=a[MSB]. ovf (SUB): a[MSB]!=b[MSB] && data_out[MSB]!=a[MSB].
- Pipeline: stage 0 registers a, b' (b or ~b), carry-in (cin, or !cin for SUB), mode, valid. Stage k (1..NSEG) computes segment k−1 from the carry registered by stage k−1 and registers it; upper segments not yet summed are carried forward unchanged, lower finished segments are carried forward (skew/de-skew registers).
- Bitwise modes use the same pipeline (same latency, carry chain forced to 0) so results never reorder.
- Stall: when out_valid && !out_ready, every stage register holds (single global enable = in_ready). Bubbles are not squeezed out during stalls.
- No combinational path from data_in to any output; only in_ready depends combinationally on out_ready.

## Timing
- Latency L = NSEG + 1 cycles from accepted input to out_valid with no stall (5 for defaults). Throughput one result per cycle.
- Reset: all stage valids, data_out, cout, ovf, out_valid = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight words discarded, nothing emitted after rst deasserts until a new word is accepted and L cycles pass.
- in_valid with in_ready low: word not taken; source must hold it.
- Simultaneous out transfer and in transfer while full: both happen; no bubble.
- Outputs hold stable while out_valid && !out_ready.
- Wrap: ADD 0xFFFF+0x0001 wraps to 0x0000 with cout=1; the carry crosses all segment boundaries across stages.

## Structure
- Package seg_adder_pkg: mode enum (MODE_ADD, MODE_SUB, MODE_XOR3, MODE_MAJ), function computing NSEG, elaboration check WIDTH % SEG == 0.
- Sub-module seg_adder_stage: one SEG-wide slice plus carry register, valid and enable; instantiated NSEG times via generate. Top handles stage 0, skew registers, ovf and handshake.

## Test plan (WIDTH=16, SEG=4)
- ADD a=0xFFFF, b=0x0001, cin=0 -> 5 cycles later data_out=0x0000, cout=1, ovf=0.
- SUB a=0x8000, b=0x0001, cin=0 -> data_out=0x7FFF, cout=1, ovf=1; SUB a=0x0001, b=0x0002 -> 0xFFFF, cout=0, ovf=0.
- XOR3 a=0x00FF, b=0x0F0F, cin=1 -> 0xF00F; MAJ same operands -> 0x0FFF; cout=ovf=0 both.
- Back-to-back 8 ADDs, out_ready=1 -> 8 consecutive out_valid cycles in order, results match reference model.
- out_ready low for 3 cycles with pipeline full -> in_ready low same cycles, data_out stable, no loss or duplication after release.
- rst asserted 2 cycles after 3 words accepted -> out_valid stays 0; next accepted word appears alone after 5 cycles.

Source files
------------

// File: rtl/seg_adder_pkg.sv
// Shared types and elaboration helpers for the segmented, pipelined adder.
// Operand width must split evenly into carry-chain segments.
package seg_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_XOR3 = 2'b10,
        MODE_MAJ  = 2'b11
    } mode_t;

    function automatic int calc_nseg(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

    function automatic logic is_arith(input mode_t m);
        return (m == MODE_ADD) || (m == MODE_SUB);
    endfunction

endpackage

// File: rtl/seg_adder_stage.sv
// One SEG-wide slice of the carry chain with its result, carry and valid registers.
// Bitwise modes ignore the carry and emit a zero carry so the chain stays quiet.
module seg_adder_stage
    import seg_adder_pkg::*;
#(
    parameter int SEG      = 4,
    parameter bit RST_DATA = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           vld_in,
    input  mode_t          mode,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    input  logic           bw_c,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           vld_out
);

    logic [SEG:0]   add_w;
    logic [SEG-1:0] rep_c;
    logic [SEG-1:0] sum_nx;
    logic           c_nx;

    assign add_w = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
    assign rep_c = {SEG{bw_c}};

    always_comb begin
        sum_nx = add_w[SEG-1:0];
        c_nx   = add_w[SEG];
        case (mode)
            MODE_XOR3: begin
                sum_nx = a ^ b ^ rep_c;
                c_nx   = 1'b0;
            end
            MODE_MAJ: begin
                sum_nx = (a & b) | (a & rep_c) | (b & rep_c);
                c_nx   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_out <= 1'b0;
        end else if (en) begin
            vld_out <= vld_in;
        end
    end

    // Only the output-facing slice clears its data so the block powers up with zero outputs.
    always_ff @(posedge clk) begin
        if (RST_DATA && rst) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else if (en) begin
            sum   <= sum_nx;
            c_out <= c_nx;
        end
    end

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined WIDTH-bit adder/subtractor/bitwise unit resolving SEG carry bits per stage,
// with a valid/ready handshake and a single global stall enable.
module pipelined_seg_adder
    import seg_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] data_in,
    input  logic               cin,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               cout,
    output logic               ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);
    localparam logic signed [WIDTH-1:0] ZERO_S = '0;

    if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("pipelined_seg_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Signed overflow: operands share a sign that the result does not. b is already inverted for SUB.
    function automatic logic signed_ovf(input mode_t m,
                                        input logic signed [WIDTH-1:0] a_s,
                                        input logic signed [WIDTH-1:0] b_s,
                                        input logic signed [WIDTH-1:0] s_s);
        return is_arith(m) && ((a_s < ZERO_S) == (b_s < ZERO_S)) && ((s_s < ZERO_S) != (a_s < ZERO_S));
    endfunction

    logic               en;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    mode_t              mode_in;

    logic               vld_p0;
    logic               c_p0;
    logic [WIDTH-1:0]   a_p     [0:NSEG];
    logic [WIDTH-1:0]   bx_p    [0:NSEG];
    mode_t              mode_p  [0:NSEG];
    logic               bwc_p   [0:NSEG-1];
    logic [WIDTH-1:0]   s_p     [1:NSEG];
    logic [SEG-1:0]     seg_sum [1:NSEG];
    logic               c_l     [0:NSEG];
    logic               vld_l   [0:NSEG];
    logic [WIDTH-1:0]   dout;

    assign op_a    = data_in[WIDTH-1:0];
    assign op_b    = data_in[2*WIDTH-1:WIDTH];
    assign mode_in = mode_t'(mode);
    assign vld_l[0] = vld_p0;
    assign c_l[0]   = c_p0;

    // ---- stage 0: capture operands, pre-invert b and the carry for subtraction ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_p[0]    <= op_a;
            bx_p[0]   <= (mode_in == MODE_SUB) ? ~op_b : op_b;
            c_p0      <= is_arith(mode_in) & (cin ^ (mode_in == MODE_SUB));
            bwc_p[0]  <= cin;
            mode_p[0] <= mode_in;
        end
    end

    // ---- stages 1..NSEG: one segment each; finished low segments ride along in s_p ----
    for (genvar k = 1; k <= NSEG; k++) begin : g_lvl
        localparam bit LAST = (k == NSEG);
        logic [WIDTH-1:0] s_nxt;

        seg_adder_stage #(
            .SEG      (SEG),
            .RST_DATA (LAST)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .vld_in  (vld_l[k-1]),
            .mode    (mode_p[k-1]),
            .a       (a_p[k-1][(k-1)*SEG +: SEG]),
            .b       (bx_p[k-1][(k-1)*SEG +: SEG]),
            .c_in    (c_l[k-1]),
            .bw_c    (bwc_p[k-1]),
            .sum     (seg_sum[k]),
            .c_out   (c_l[k]),
            .vld_out (vld_l[k])
        );

        if (k == 1) begin : g_first
            assign s_nxt = '0;
        end else begin : g_skew
            always_comb begin
                s_nxt = s_p[k-1];
                s_nxt[(k-2)*SEG +: SEG] = seg_sum[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (LAST && rst) begin
                a_p[k]    <= '0;
                bx_p[k]   <= '0;
                mode_p[k] <= MODE_ADD;
                s_p[k]    <= '0;
            end else if (en) begin
                a_p[k]    <= a_p[k-1];
                bx_p[k]   <= bx_p[k-1];
                mode_p[k] <= mode_p[k-1];
                s_p[k]    <= s_nxt;
            end
        end

        if (k < NSEG) begin : g_bwc
            always_ff @(posedge clk) begin
                if (en) begin
                    bwc_p[k] <= bwc_p[k-1];
                end
            end
        end
    end

    // ---- output: merge the top segment with the de-skewed lower ones ----
    always_comb begin
        dout = s_p[NSEG];
        dout[(NSEG-1)*SEG +: SEG] = seg_sum[NSEG];
    end

    assign data_out  = dout;
    assign out_valid = vld_l[NSEG];
    assign cout      = is_arith(mode_p[NSEG]) & c_l[NSEG];
    assign ovf       = signed_ovf(mode_p[NSEG], a_p[NSEG], bx_p[NSEG], dout);
    assign in_ready  = !(out_valid && !out_ready);
    assign en        = in_ready;

endmodule
